pll_fb_divider: RTL and testbench

- Programmable feedback divider for the implantable PLL loop.
- Divides the VCO clock by a programmable ratio N and drives the feedback input (B) of the phase-frequency detector.
- Produces a near-50%-duty feedback clock plus a one-cycle terminal-count strobe.
- Ratio changes are glitch-free: they take effect only at a period boundary.

---
 rtl/pll_fb_divider.sv | 146 ++++++++++++++
 tb/tb_pll_fb_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pll_fb_divider.sv
// Programmable PLL feedback divider: divides Clk by N, near-50% FB plus a terminal-count strobe.
// Optional first-order fractional accumulator when FB_FRAC_DIV_EN is defined.
module pll_fb_divider #(
    parameter int unsigned W       = 8,
    parameter int unsigned DEF_DIV = 4,
    parameter int unsigned FW      = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Enable,
    input  logic [W-1:0]  Div,
    input  logic          Load,
`ifdef FB_FRAC_DIV_EN
    input  logic [FW-1:0] Frac,
`endif
    output logic          FB,
    output logic          Tc,
    output logic [W-1:0]  DivAct
);

    localparam int unsigned CW = W + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  div_act_q, div_act_d;
    logic [W-1:0]  pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          fb_q, fb_d;
    logic          tc_q, tc_d;

    logic [W-1:0]  div_clamped;
    logic [W-1:0]  div_sel;
    logic          carry_cur;
    logic          carry_new;
    logic [CW-1:0] nact;
    logic [CW-1:0] nact_nxt;
    logic [CW-1:0] half_nxt;
    logic          wrap;

    assign div_clamped = (Div < W'(2)) ? W'(2) : Div;
    // A fresh Load wins over an older pending value.
    assign div_sel     = Load ? div_clamped : (pend_vld_q ? pend_q : div_act_q);
    assign nact        = {1'b0, div_act_q} + CW'(carry_cur);
    assign wrap        = (cnt_q == nact - CW'(1));

`ifdef FB_FRAC_DIV_EN
    logic [FW-1:0] frac_act_q, frac_act_d;
    logic [FW-1:0] frac_pend_q, frac_pend_d;
    logic [FW-1:0] acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [FW-1:0] frac_sel;
    logic [FW-1:0] acc_new;

    assign frac_sel             = Load ? Frac : (pend_vld_q ? frac_pend_q : frac_act_q);
    assign {carry_new, acc_new} = {1'b0, acc_q} + {1'b0, frac_sel};
    assign carry_cur            = carry_q;

    always_comb begin
        frac_act_d  = frac_act_q;
        frac_pend_d = Load ? Frac : frac_pend_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        if (!Enable) begin
            frac_act_d = frac_sel;
        end else if (wrap) begin
            frac_act_d = frac_sel;
            acc_d      = acc_new;
            carry_d    = carry_new;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frac_act_q  <= '0;
            frac_pend_q <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
        end else begin
            frac_act_q  <= frac_act_d;
            frac_pend_q <= frac_pend_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
        end
    end
`else
    assign carry_cur = 1'b0;
    assign carry_new = 1'b0;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        nact_nxt   = nact;
        fb_d       = 1'b0;
        tc_d       = 1'b0;

        if (Load) begin
            pend_d     = div_clamped;
            pend_vld_d = 1'b1;
        end

        if (!Enable) begin
            // Parked at the last count so the first enabled edge wraps to 0.
            div_act_d  = div_sel;
            pend_vld_d = 1'b0;
            cnt_d      = {1'b0, div_sel} + CW'(carry_cur) - CW'(1);
        end else begin
            if (wrap) begin
                div_act_d  = div_sel;
                pend_vld_d = 1'b0;
                cnt_d      = '0;
                nact_nxt   = {1'b0, div_sel} + CW'(carry_new);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            fb_d = (cnt_d < half_nxt);
            tc_d = (cnt_d == nact_nxt - CW'(1));
        end
    end

    assign half_nxt = (nact_nxt + CW'(1)) >> 1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q      <= CW'(DEF_DIV - 1);
            div_act_q  <= W'(DEF_DIV);
            pend_q     <= W'(DEF_DIV);
            pend_vld_q <= 1'b0;
            fb_q       <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            fb_q       <= fb_d;
            tc_q       <= tc_d;
        end
    end

    assign FB     = fb_q;
    assign Tc     = tc_q;
    assign DivAct = div_act_q;

endmodule

// File: tb/tb_pll_fb_divider.sv
// Scoreboard bench for pll_fb_divider: stimulus pushes expected {FB,Tc,DivAct} per cycle,
// a monitor pops and compares after every clock edge.
module tb_pll_fb_divider;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div;
    logic       ld;
`ifdef FB_FRAC_DIV_EN
    logic [7:0] frac;
`endif
    logic       fb;
    logic       tc;
    logic [7:0] div_act;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];

    pll_fb_divider #(
        .W      (8),
        .DEF_DIV(4),
        .FW     (8)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .Enable(en),
        .Div   (div),
        .Load  (ld),
`ifdef FB_FRAC_DIV_EN
        .Frac  (frac),
`endif
        .FB    (fb),
        .Tc    (tc),
        .DivAct(div_act)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected entry per edge while stimulus is active.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({fb, tc, div_act} !== e) begin
                    bad++;
                    $display("FAIL cyc t=%0t fb/tc/div got %b/%b/%0d want %b/%b/%0d",
                             $time, fb, tc, div_act, e[9], e[8], e[7:0]);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic efb, input logic etc,
                             input int ediv);
        total++;
        if (fb !== efb || tc !== etc || div_act !== 8'(ediv)) begin
            bad++;
            $display("FAIL %s fb/tc/div got %b/%b/%0d want %b/%b/%0d",
                     name, fb, tc, div_act, efb, etc, ediv);
        end
    endtask

    task automatic cyc(input logic en_v, input logic ld_v, input int div_v,
                       input logic efb, input logic etc, input int ediv);
        @(negedge clk);
        en  = en_v;
        ld  = ld_v;
        div = 8'(div_v);
        exp_q.push_back({efb, etc, 8'(ediv)});
    endtask

    // One enabled FB period of n cycles; optional Load at cycle index ld_at (0 = wrap edge).
    task automatic period(input int n, input int ediv, input int ld_at, input int ld_div);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, (i == ld_at), (i == ld_at) ? ld_div : 0,
                (i < (n + 1) / 2), (i == n - 1), ediv);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        en  = 1'b0;
        ld  = 1'b0;
        div = 8'd0;
`ifdef FB_FRAC_DIV_EN
        frac = 8'h00;
`endif
        rst = 1'b1;
        #1;
        check_now("reset_vals", 1'b0, 1'b0, 4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Load 4 while disabled, then enable: FB 1100, Tc on last low cycle.
        cyc(1'b0, 1'b1, 4, 1'b0, 1'b0, 4);
        repeat (3) period(4, 4, -1, 0);

        // Load at the wrap edge governs the period starting there.
        period(5, 5, 0, 5);
        period(5, 5, -1, 0);
        period(255, 255, 0, 255);
        period(4, 4, 0, 4);

        // Mid-period load: current period finishes at 4, then 7.
        period(4, 4, 2, 7);
        period(7, 7, -1, 0);
        period(7, 7, -1, 0);

        // Last load before the wrap wins (9 then 5).
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 7);
        cyc(1'b1, 1'b1, 9, 1'b1, 1'b0, 7);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 7);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 7);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 7);
        cyc(1'b1, 1'b1, 5, 1'b0, 1'b0, 7);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 7);
        period(5, 5, -1, 0);

        // Clamp: Div 0 and 1 both become 2.
        period(2, 2, 0, 0);
        period(2, 2, 0, 1);
        period(2, 2, -1, 0);
        period(2, 2, -1, 0);

        // Enable falls mid-period, load while disabled takes effect on the next edge.
        period(4, 4, 0, 4);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 4);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 4);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 4);
        cyc(1'b0, 1'b1, 3, 1'b0, 1'b0, 3);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 3);
        period(3, 3, -1, 0);
        period(3, 3, -1, 0);

        // Async reset at cnt=2 of a Div=6 period.
        period(6, 6, 0, 6);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 6);
        cyc(1'b1, 1'b0, 0, 1'b1, 1'b0, 6);
        cyc(1'b1, 1'b1, 9, 1'b1, 1'b0, 6);
        @(posedge clk);
        #3;
        en  = 1'b0;
        ld  = 1'b0;
        rst = 1'b1;
        #1;
        check_now("reset_async", 1'b0, 1'b0, 4);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 4);
        period(4, 4, -1, 0);
        period(4, 4, -1, 0);

`ifdef FB_FRAC_DIV_EN
        // Div=4, Frac=0x40: periods 4,4,4,5 repeating, DivAct stays 4.
        frac = 8'h40;
        period(4, 4, 0, 4);
        period(4, 4, -1, 0);
        period(4, 4, -1, 0);
        period(5, 4, -1, 0);
        period(4, 4, -1, 0);
        period(4, 4, -1, 0);
        period(4, 4, -1, 0);
        period(5, 4, -1, 0);
`endif

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
